lfsr32_checker: RTL and testbench
=================================

Name: lfsr32_checker

Overview:
Receive-side checker for the 32-bit pseudo-random word stream made by the team's LFSR generator (taps 32, 31, 30, 10; one-bit shift per word).
- Self-synchronises to an incoming stream and predicts each next word.
- Counts checked words and mismatched words.
- Reports lock status.
- Sits at the sink end of datapath/loopback tests, opposite the generator.

Parameters:
LOCK_COUNT, 4, consecutive correct predictions needed in SEARCH to declare lock (1..255)
LOSS_COUNT, 8, consecutive mispredictions in LOCKED that drop lock (1..255)
CNT_WIDTH, 32, width of word_count and error_count

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_vld  input  1  in_data valid this cycle; no backpressure, a word every cycle is allowed
in_data  input  32  received word, indexed [32:1], same bit numbering as the generator
clear_counters  input  1  single-cycle pulse: zero both counters and lock_lost
locked  output  1  checker is in LOCKED state
err_pulse  output  1  one-cycle pulse per mismatched word while locked
lock_lost  output  1  sticky: lock was dropped since last clear/reset
word_count  output  CNT_WIDTH  words checked while LOCKED, saturating
error_count  output  CNT_WIDTH  mismatched words while LOCKED, saturating

Behaviour:
- Step function: next(v) = {v[31:1], v[32]^v[31]^v[30]^v[10]}.
- State: pred (32), match_cnt (8), miss_cnt (8), have_seed (1), fsm in {SEARCH, LOCKED}.
- Reset values:
  - fsm = SEARCH; pred, match_cnt, miss_cnt, have_seed = 0.
  - All outputs 0.
  - Reset mid-stream discards all state; no partial-lock carry-over.
- All outputs are registered and update one cycle after the in_vld word they reflect. Nothing changes in cycles with in_vld = 0.
- SEARCH, per valid word w:
  - w == 0 (LFSR lock-up value): rejected; have_seed = 0, match_cnt = 0.
  - else if !have_seed, or w != pred: pred = next(w); have_seed = 1; match_cnt = 0 (reseed on w).
  - else (match): pred = next(w); match_cnt++.
  - When match_cnt reaches LOCK_COUNT: fsm = LOCKED, miss_cnt = 0.
  - locked rises the cycle after the LOCK_COUNT-th match, so lock needs 1 + LOCK_COUNT words minimum.
  - Words in SEARCH never touch the counters.
- LOCKED, per valid word w:
  - w == pred: word_count++, miss_cnt = 0.
  - w != pred: word_count++, error_count++, err_pulse = 1, miss_cnt++.
  - pred = next(pred) in both cases. The checker free-runs on its own prediction, so an isolated corrupt word costs exactly one error and no resync.
  - When miss_cnt reaches LOSS_COUNT: fsm = SEARCH, lock_lost = 1, have_seed = 0, match_cnt = 0.
  - locked falls the cycle after the LOSS_COUNT-th consecutive miss; that word is still counted.
- Counters saturate at all-ones and never wrap.
- clear_counters:
  - Zeroes word_count, error_count and lock_lost next cycle.
  - Takes priority over any increment or lock_lost set in the same cycle; that cycle's event is dropped.
  - Does not affect fsm or pred.
- err_pulse is 0 in every cycle without a locked mismatch.

Decomposition:
- Package lfsr32_pkg holds:
  - Tap position constants (32, 31, 30, 10) and the 32-bit word type.
  - Function lfsr32_step implementing next(v), shared with the generator.
  - FSM state enumeration {SEARCH, LOCKED}.
- No sub-module: step logic is a package function, and the FSM plus counters form a single module.

Test Plan:
- Lock: reset; stream from seed 0x00000001 (0x1, 0x2, 0x4, 0x8, 0x10, ...), in_vld every cycle, LOCK_COUNT = 4 -> locked = 1 one cycle after 5th word (0x10); the 0x200 -> 0x401 step matches; word_count increments per word thereafter; error_count = 0.
- Single error: while locked, flip bit 1 of one word (0x401 sent as 0x400), next words correct -> exactly one err_pulse, error_count = 1, locked stays 1, no lock_lost.
- Loss of lock: while locked, send 8 consecutive 0xDEADBEEF -> error_count = 8, locked falls after 8th, lock_lost = 1; resume a valid stream from any nonzero seed -> relock after 5 words.
- Zero stream and gaps: send all-zero words for 20 cycles -> never locks, counters 0. Then a valid stream with in_vld toggling 1/0 -> locks after 5 valid words; idle cycles change nothing.
- Clear/saturation: CNT_WIDTH = 4, locked with 20 bad words (LOSS_COUNT = 255) -> error_count holds 0xF. Pulse clear_counters coincident with a mismatch -> both counters 0 next cycle, lock_lost 0.
- Reset mid-operation: assert reset while locked with nonzero counters -> all outputs 0 next cycle, fsm SEARCH; the next 4 stream words do not lock.

Source files
------------

// File: rtl/lfsr32_pkg.sv
// Shared definitions for the 32-bit LFSR generator/checker pair (taps 32, 31, 30, 10).
package lfsr32_pkg;

    localparam int unsigned LFSR_WIDTH = 32;
    localparam int unsigned TAP_0      = 32;
    localparam int unsigned TAP_1      = 31;
    localparam int unsigned TAP_2      = 30;
    localparam int unsigned TAP_3      = 10;
    localparam int unsigned SEQ_CNT_W  = 8;

    // Word bits are numbered [32:1] to match the generator documentation.
    typedef logic [LFSR_WIDTH:1] lfsr32_word_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lfsr32_state_e;

    // One-bit shift toward bit 32, feedback into bit 1.
    function automatic lfsr32_word_t lfsr32_step(input lfsr32_word_t v);
        return {v[LFSR_WIDTH-1:1], v[TAP_0] ^ v[TAP_1] ^ v[TAP_2] ^ v[TAP_3]};
    endfunction

endpackage

// File: rtl/lfsr32_checker.sv
// Sink-side LFSR stream checker: self-synchronises, predicts, counts words and errors.
module lfsr32_checker
    import lfsr32_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_vld,
    input  logic [32:1]          in_data,
    input  logic                 clear_counters,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] error_count
);

    localparam logic [SEQ_CNT_W-1:0] LOCK_THRESH = SEQ_CNT_W'(LOCK_COUNT);
    localparam logic [SEQ_CNT_W-1:0] LOSS_THRESH = SEQ_CNT_W'(LOSS_COUNT);
    localparam logic [SEQ_CNT_W-1:0] SEQ_ONE     = SEQ_CNT_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    lfsr32_state_e          state_q, state_d;
    lfsr32_word_t           pred_q, pred_d;
    logic [SEQ_CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [SEQ_CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic                   have_seed_q, have_seed_d;
    logic                   err_pulse_q, err_pulse_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [CNT_WIDTH-1:0]   word_count_q, word_count_d;
    logic [CNT_WIDTH-1:0]   error_count_q, error_count_d;

    logic                   hit_c;
    logic [SEQ_CNT_W-1:0]   match_inc_c;
    logic [SEQ_CNT_W-1:0]   miss_inc_c;

    // Comparison and sequence-counter increments used by the next-state logic.
    always_comb begin
        hit_c       = (in_data == pred_q);
        match_inc_c = match_cnt_q + SEQ_ONE;
        miss_inc_c  = miss_cnt_q + SEQ_ONE;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEARCH;
            pred_q        <= '0;
            match_cnt_q   <= '0;
            miss_cnt_q    <= '0;
            have_seed_q   <= 1'b0;
            err_pulse_q   <= 1'b0;
            lock_lost_q   <= 1'b0;
            word_count_q  <= '0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pred_q        <= pred_d;
            match_cnt_q   <= match_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            have_seed_q   <= have_seed_d;
            err_pulse_q   <= err_pulse_d;
            lock_lost_q   <= lock_lost_d;
            word_count_q  <= word_count_d;
            error_count_q <= error_count_d;
        end
    end

    // Next-state: seed/match search, free-running check while locked, counter clear.
    always_comb begin
        state_d       = state_q;
        pred_d        = pred_q;
        match_cnt_d   = match_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        have_seed_d   = have_seed_q;
        err_pulse_d   = 1'b0;
        lock_lost_d   = lock_lost_q;
        word_count_d  = word_count_q;
        error_count_d = error_count_q;

        if (in_vld) begin
            unique case (state_q)
                SEARCH: begin
                    if (in_data == '0) begin
                        // All-zero is the LFSR lock-up value and never a valid seed.
                        have_seed_d = 1'b0;
                        match_cnt_d = '0;
                    end else if (!have_seed_q || !hit_c) begin
                        pred_d      = lfsr32_step(in_data);
                        have_seed_d = 1'b1;
                        match_cnt_d = '0;
                    end else begin
                        pred_d      = lfsr32_step(in_data);
                        match_cnt_d = match_inc_c;
                        if (match_inc_c == LOCK_THRESH) begin
                            state_d     = LOCKED;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    pred_d = lfsr32_step(pred_q);
                    if (word_count_q != CNT_MAX) begin
                        word_count_d = word_count_q + CNT_ONE;
                    end
                    if (hit_c) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        miss_cnt_d  = miss_inc_c;
                        if (error_count_q != CNT_MAX) begin
                            error_count_d = error_count_q + CNT_ONE;
                        end
                        if (miss_inc_c == LOSS_THRESH) begin
                            state_d     = SEARCH;
                            lock_lost_d = 1'b1;
                            have_seed_d = 1'b0;
                            match_cnt_d = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear wins over any same-cycle increment or lock_lost set.
        if (clear_counters) begin
            word_count_d  = '0;
            error_count_d = '0;
            lock_lost_d   = 1'b0;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign err_pulse   = err_pulse_q;
    assign lock_lost   = lock_lost_q;
    assign word_count  = word_count_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_lfsr32_checker.sv
// Directed bench for lfsr32_checker: default instance plus a 4-bit-counter, LOSS_COUNT=255 instance.
module tb_lfsr32_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_vld, clear_counters;
    logic [31:0] in_data;
    logic        locked, err_pulse, lock_lost;
    logic [31:0] word_count, error_count;

    logic        s_reset, s_in_vld, s_clear;
    logic [31:0] s_in_data;
    logic        s_locked, s_err_pulse, s_lock_lost;
    logic [3:0]  s_word_count, s_error_count;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cur;
    logic [31:0] s_cur;

    lfsr32_checker dut (
        .clk            (clk),
        .reset          (reset),
        .in_vld         (in_vld),
        .in_data        (in_data),
        .clear_counters (clear_counters),
        .locked         (locked),
        .err_pulse      (err_pulse),
        .lock_lost      (lock_lost),
        .word_count     (word_count),
        .error_count    (error_count)
    );

    lfsr32_checker #(.LOCK_COUNT(4), .LOSS_COUNT(255), .CNT_WIDTH(4)) dut_sat (
        .clk            (clk),
        .reset          (s_reset),
        .in_vld         (s_in_vld),
        .in_data        (s_in_data),
        .clear_counters (s_clear),
        .locked         (s_locked),
        .err_pulse      (s_err_pulse),
        .lock_lost      (s_lock_lost),
        .word_count     (s_word_count),
        .error_count    (s_error_count)
    );

    // Reference step written on 0-based bits: taps 32,31,30,10 are bits 31,30,29,9.
    function automatic logic [31:0] model_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[30] ^ v[29] ^ v[9]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic clr);
        @(negedge clk);
        in_vld = v;
        in_data = d;
        clear_counters = clr;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        clear_counters = 1'b0;
    endtask

    task automatic send_good();
        drive(1'b1, cur, 1'b0);
        cur = model_step(cur);
    endtask

    task automatic send_bad(input logic [31:0] d, input logic clr);
        drive(1'b1, d, clr);
        cur = model_step(cur);
    endtask

    task automatic drive_s(input logic v, input logic [31:0] d, input logic clr);
        @(negedge clk);
        s_in_vld = v;
        s_in_data = d;
        s_clear = clr;
        @(posedge clk);
        #1;
        s_in_vld = 1'b0;
        s_clear = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_vld = 1'b0; in_data = '0; clear_counters = 1'b0;
        s_reset = 1'b1; s_in_vld = 1'b0; s_in_data = '0; s_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_err", 32'(err_pulse), 32'd0);
        check_eq("rst_lost", 32'(lock_lost), 32'd0);
        check_eq("rst_wc", word_count, 32'd0);
        check_eq("rst_ec", error_count, 32'd0);
        reset = 1'b0;
        s_reset = 1'b0;

        // Lock on the stream from seed 1.
        cur = 32'h1;
        repeat (4) send_good();
        check_eq("lock_not_yet", 32'(locked), 32'd0);
        send_good();
        check_eq("lock_after_5", 32'(locked), 32'd1);
        check_eq("lock_wc0", word_count, 32'd0);
        repeat (5) send_good();
        check_eq("locked_wc5", word_count, 32'd5);
        drive(1'b1, 32'h0000_0401, 1'b0);
        cur = 32'h0000_0802;
        check_eq("tap_step_err", 32'(err_pulse), 32'd0);
        check_eq("tap_step_wc", word_count, 32'd6);
        check_eq("tap_step_ec", error_count, 32'd0);

        // Single corrupted word: one error, no resync.
        send_bad(32'h0000_0803, 1'b0);
        check_eq("single_err_pulse", 32'(err_pulse), 32'd1);
        check_eq("single_ec", error_count, 32'd1);
        check_eq("single_wc", word_count, 32'd7);
        repeat (3) send_good();
        check_eq("after_err_pulse", 32'(err_pulse), 32'd0);
        check_eq("after_err_ec", error_count, 32'd1);
        check_eq("after_err_wc", word_count, 32'd10);
        check_eq("after_err_locked", 32'(locked), 32'd1);
        check_eq("after_err_lost", 32'(lock_lost), 32'd0);

        // Idle clear.
        drive(1'b0, 32'h0, 1'b1);
        check_eq("clr_wc", word_count, 32'd0);
        check_eq("clr_ec", error_count, 32'd0);
        check_eq("clr_locked", 32'(locked), 32'd1);

        // Loss of lock after 8 consecutive misses.
        repeat (7) send_bad(32'hDEAD_BEEF, 1'b0);
        check_eq("loss7_locked", 32'(locked), 32'd1);
        check_eq("loss7_ec", error_count, 32'd7);
        send_bad(32'hDEAD_BEEF, 1'b0);
        check_eq("loss8_locked", 32'(locked), 32'd0);
        check_eq("loss8_ec", error_count, 32'd8);
        check_eq("loss8_wc", word_count, 32'd8);
        check_eq("loss8_lost", 32'(lock_lost), 32'd1);
        check_eq("loss8_err", 32'(err_pulse), 32'd1);
        drive(1'b0, 32'hDEAD_BEEF, 1'b0);
        check_eq("idle_err", 32'(err_pulse), 32'd0);
        check_eq("idle_ec", error_count, 32'd8);

        // Relock on a fresh seed.
        cur = 32'h1234_5678;
        repeat (4) send_good();
        check_eq("relock_not_yet", 32'(locked), 32'd0);
        check_eq("search_wc_frozen", word_count, 32'd8);
        send_good();
        check_eq("relock", 32'(locked), 32'd1);
        check_eq("relock_lost_sticky", 32'(lock_lost), 32'd1);

        // Clear coincident with a mismatch: clear wins.
        send_bad(~cur, 1'b1);
        check_eq("clrpri_wc", word_count, 32'd0);
        check_eq("clrpri_ec", error_count, 32'd0);
        check_eq("clrpri_lost", 32'(lock_lost), 32'd0);
        check_eq("clrpri_err", 32'(err_pulse), 32'd1);
        repeat (3) send_good();
        check_eq("post_clr_wc", word_count, 32'd3);
        check_eq("post_clr_ec", error_count, 32'd0);

        // Reset mid-operation discards all state.
        pulse_reset();
        check_eq("midrst_locked", 32'(locked), 32'd0);
        check_eq("midrst_wc", word_count, 32'd0);
        check_eq("midrst_ec", error_count, 32'd0);
        repeat (4) send_good();
        check_eq("midrst_no_lock4", 32'(locked), 32'd0);
        send_good();
        check_eq("midrst_lock5", 32'(locked), 32'd1);

        // Zero stream never seeds; idle cycles change nothing.
        pulse_reset();
        repeat (20) drive(1'b1, 32'h0, 1'b0);
        check_eq("zero_locked", 32'(locked), 32'd0);
        check_eq("zero_wc", word_count, 32'd0);
        cur = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            send_good();
            drive(1'b0, 32'hFFFF_FFFF, 1'b0);
        end
        check_eq("gap_no_lock4", 32'(locked), 32'd0);
        send_good();
        check_eq("gap_lock5", 32'(locked), 32'd1);
        drive(1'b0, 32'h5555_AAAA, 1'b0);
        check_eq("gap_idle_locked", 32'(locked), 32'd1);
        check_eq("gap_idle_wc", word_count, 32'd0);
        check_eq("gap_idle_err", 32'(err_pulse), 32'd0);
        send_good();
        check_eq("gap_wc1", word_count, 32'd1);
        check_eq("gap_ec0", error_count, 32'd0);

        // Saturation on the 4-bit counter instance.
        s_cur = 32'h1;
        for (int i = 0; i < 5; i++) begin
            drive_s(1'b1, s_cur, 1'b0);
            s_cur = model_step(s_cur);
        end
        check_eq("sat_locked", 32'(s_locked), 32'd1);
        for (int i = 0; i < 20; i++) begin
            drive_s(1'b1, 32'hDEAD_BEEF, 1'b0);
            s_cur = model_step(s_cur);
        end
        check_eq("sat_ec", 32'(s_error_count), 32'hF);
        check_eq("sat_wc", 32'(s_word_count), 32'hF);
        check_eq("sat_still_locked", 32'(s_locked), 32'd1);
        check_eq("sat_lost", 32'(s_lock_lost), 32'd0);
        drive_s(1'b1, 32'hDEAD_BEEF, 1'b1);
        s_cur = model_step(s_cur);
        check_eq("sat_clr_ec", 32'(s_error_count), 32'd0);
        check_eq("sat_clr_wc", 32'(s_word_count), 32'd0);
        check_eq("sat_clr_err", 32'(s_err_pulse), 32'd1);
        drive_s(1'b1, s_cur, 1'b0);
        check_eq("sat_post_wc", 32'(s_word_count), 32'd1);
        check_eq("sat_post_ec", 32'(s_error_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
